// File: rtl/ascon_perm_ctrl.sv
// Round-sequencing controller for an Ascon permutation datapath.
// Runs p^a or p^b. Rounds run from 12-ROUNDS up to 11. Supports stall and
// a synchronous active-low reset.
module ascon_perm_ctrl #(
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       mode_i,
   input  logic       hold_i,
   output logic [3:0] round_o,
   output logic       sel_o,
   output logic       en_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int unsigned ROUND_W    = 4;
   localparam int unsigned LAST_ROUND = 11;
   localparam int unsigned R0_A       = 12 - ROUNDS_A;
   localparam int unsigned R0_B       = 12 - ROUNDS_B;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ROUND_W-1:0]   cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic [ROUND_W-1:0]   start_round;

   // State, round counter and latched mode; reset wins over everything.
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state and output decode; en_o tracks the stall directly so a held
   // cycle never writes the datapath state register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      round_o     = '0;
      sel_o       = 1'b0;
      en_o        = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      start_round = mode_q ? ROUND_W'(R0_B) : ROUND_W'(R0_A);

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = FIRST;
               mode_d  = mode_i;
               cnt_d   = '0;
            end
         end
         FIRST: begin
            round_o = start_round;
            en_o    = !hold_i;
            busy_o  = 1'b1;
            if (!hold_i) begin
               if (start_round == ROUND_W'(LAST_ROUND)) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
                  cnt_d   = start_round + ROUND_W'(1);
               end
            end
         end
         RUN: begin
            round_o = cnt_q;
            sel_o   = 1'b1;
            en_o    = !hold_i;
            busy_o  = 1'b1;
            if (!hold_i) begin
               if (cnt_q == ROUND_W'(LAST_ROUND)) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + ROUND_W'(1);
               end
            end
         end
         DONE: begin
            round_o = ROUND_W'(LAST_ROUND);
            sel_o   = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: reset, p^a/p^b sequencing, stalls,
// mid-run reset and back-to-back starts.
module tb_ascon_perm_ctrl;

   logic       clock_i;
   logic       resetb_i;
   logic       start_i;
   logic       mode_i;
   logic       hold_i;
   logic [3:0] round_o;
   logic       sel_o;
   logic       en_o;
   logic       busy_o;
   logic       done_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] outs;
   assign outs = {round_o, sel_o, en_o, busy_o, done_o};

   ascon_perm_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .start_i  (start_i),
      .mode_i   (mode_i),
      .hold_i   (hold_i),
      .round_o  (round_o),
      .sel_o    (sel_o),
      .en_o     (en_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   // Single comparison point for every check in the bench.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] vec(input logic [3:0] r, input logic s, input logic e,
                                      input logic b, input logic d);
      return {r, s, e, b, d};
   endfunction

   // One permutation run: accept, per-cycle round/sel/en/busy, done pulse and latency.
   // Tasks start and end at posedge+1; outputs are sampled at posedge+5.
   task automatic run_perm(input string tag, input logic m, input int hold_round,
                           input int hold_n, input int exp_lat);
      int   r;
      bit   first;
      bit   ending;
      int   held;
      int   done_cyc;
      logic h;
      start_i = 1'b1;
      mode_i  = m;
      hold_i  = 1'b0;
      #4;
      check_eq({tag, "_accept"}, 32'(outs), 32'(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(posedge clock_i); #1;
      start_i  = 1'b0;
      mode_i   = ~m;
      r        = m ? 6 : 0;
      first    = 1'b1;
      ending   = 1'b0;
      held     = 0;
      done_cyc = 0;
      for (int cyc = 1; cyc < 40; cyc++) begin
         h      = (!ending && r == hold_round && held < hold_n);
         hold_i = h | ending;
         #4;
         if (done_o && done_cyc == 0) done_cyc = cyc;
         if (ending) begin
            check_eq({tag, "_done"}, 32'(outs), 32'(vec(4'd11, 1'b1, 1'b0, 1'b0, 1'b1)));
            break;
         end
         check_eq($sformatf("%s_c%0d", tag, cyc), 32'(outs),
                  32'(vec(4'(r), !first, !h, 1'b1, 1'b0)));
         if (h) begin
            held++;
         end else begin
            if (r == 11) ending = 1'b1;
            else         r++;
            first = 1'b0;
         end
         @(posedge clock_i); #1;
      end
      hold_i = 1'b0;
      check_eq({tag, "_latency"}, 32'(done_cyc), 32'(exp_lat));
      @(posedge clock_i); #1;
      hold_i = 1'b1;
      #4;
      check_eq({tag, "_idle"}, 32'(outs), 32'(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(posedge clock_i); #1;
      hold_i = 1'b0;
   endtask

   // Reset pulse while round 7 is active, including an inter-edge drop of resetb_i.
   task automatic reset_mid_run();
      bit found;
      found   = 1'b0;
      start_i = 1'b1;
      mode_i  = 1'b0;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #4;
         if (round_o == 4'd7 && busy_o) begin
            found = 1'b1;
            break;
         end
         @(posedge clock_i); #1;
      end
      check_eq("rst_found_r7", 32'(found), 32'd1);
      resetb_i = 1'b0;
      start_i  = 1'b1;
      #2;
      check_eq("rst_sync_only", 32'(outs), 32'(vec(4'd7, 1'b1, 1'b1, 1'b1, 1'b0)));
      @(posedge clock_i); #1;
      resetb_i = 1'b1;
      start_i  = 1'b0;
      #4;
      check_eq("rst_idle", 32'(outs), 32'(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(posedge clock_i); #1;
      #4;
      check_eq("rst_no_start", 32'(outs), 32'(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(posedge clock_i); #1;
   endtask

   // start_i held high: runs restart every 14 cycles, never while busy.
   task automatic back_to_back();
      int first_done;
      int second_done;
      int n_done;
      bit busy_start;
      first_done  = 0;
      second_done = 0;
      n_done      = 0;
      busy_start  = 1'b0;
      start_i = 1'b1;
      mode_i  = 1'b0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(posedge clock_i); #1;
         #4;
         if (done_o) begin
            n_done++;
            if (first_done == 0)       first_done  = cyc;
            else if (second_done == 0) second_done = cyc;
         end
         if (busy_o && round_o == 4'd0 && sel_o && en_o) busy_start = 1'b1;
      end
      start_i = 1'b0;
      check_eq("b2b_first_done", 32'(first_done), 32'd13);
      check_eq("b2b_second_done", 32'(second_done), 32'd27);
      check_eq("b2b_done_count", 32'(n_done), 32'd2);
      check_eq("b2b_no_restart_busy", 32'(busy_start), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clock_i); #1;
      end
      #4;
      check_eq("b2b_drained", 32'(outs), 32'(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
   endtask

   initial begin
      resetb_i = 1'b0;
      start_i  = 1'b1;
      mode_i   = 1'b1;
      hold_i   = 1'b0;
      @(posedge clock_i); #1;
      #4;
      check_eq("reset_c0", 32'(outs), 32'(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(posedge clock_i); #1;
      #4;
      check_eq("reset_c1", 32'(outs), 32'(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(posedge clock_i); #1;
      resetb_i = 1'b1;

      run_perm("pa",          1'b0, -1, 0, 13);
      run_perm("pb",          1'b1, -1, 0, 7);
      run_perm("pa_hold4",    1'b0,  4, 3, 16);
      run_perm("pb_hold1st",  1'b1,  6, 2, 9);
      reset_mid_run();
      run_perm("pa_post_rst", 1'b0, -1, 0, 13);
      back_to_back();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
